// File: rtl/muldiv_if.sv
// Operand/command and HI/LO result bundle between the CPU datapath and the mul/div unit.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide with architectural HI/LO; 33 clocks from start to result.
// Multiply is shift-add, divide is restoring; signed ops run on magnitudes and are fixed up at the end.
module muldiv_unit (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic [31:0] a_q;
  logic [31:0] hi_q, lo_q;
  logic        mul_q;
  logic        neg_q;
  logic        a_neg_q;
  logic        done_q;

  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [63:0] step;
  logic [32:0] mul_sum;
  logic [32:0] div_rem;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi, fix_lo;
  logic        accept;
  logic        mt_ok;

  assign a_neg  = bus.op[0] & bus.a[31];
  assign b_neg  = bus.op[0] & bus.b[31];
  assign a_abs  = a_neg ? -bus.a : bus.a;
  assign b_abs  = b_neg ? -bus.b : bus.b;
  assign accept = (state_q == StIdle) & bus.start;
  assign mt_ok  = (state_q == StIdle) & ~bus.start;

  // One iteration: multiply keeps {partial product, remaining multiplier},
  // divide keeps {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_rem  = {acc_q[63:32], acc_q[31]};
    div_diff = div_rem - {1'b0, opnd_q};
    if (mul_q) begin
      step = {mul_sum, acc_q[31:1]};
    end else if (!div_diff[32]) begin
      step = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      step = {div_rem[31:0], acc_q[30:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    if (mul_q) begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end else if (opnd_q == 32'd0) begin
      fix_hi = a_q;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = a_neg_q ? -acc_q[63:32] : acc_q[63:32];
      fix_lo = neg_q ? -acc_q[31:0] : acc_q[31:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (cnt_q == 5'd31) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        cnt_q   <= '0;
        mul_q   <= ~bus.op[1];
        neg_q   <= a_neg ^ b_neg;
        a_neg_q <= a_neg;
        a_q     <= bus.a;
        acc_q   <= bus.op[1] ? {32'd0, a_abs} : {32'd0, b_abs};
        opnd_q  <= bus.op[1] ? b_abs : a_abs;
      end else if (state_q == StRun) begin
        cnt_q <= cnt_q + 5'd1;
        acc_q <= step;
      end else if (state_q == StFix) begin
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
        done_q <= 1'b1;
      end
      if (mt_ok && bus.we_hi) hi_q <= bus.wd;
      if (mt_ok && bus.we_lo) lo_q <= bus.wd;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS CPU datapath. It sits beside the ALU, takes its operands from regfile read ports rd1/rd2, and feeds HI/LO to the writeback mux for mfhi/mflo. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. Control stalls the pipeline while `busy` is high.

## Interface
Parameters:
- None. The datapath width is fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  request an operation. Sampled only in IDLE.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- we_hi  in  1  MTHI: write wd into HI
- we_lo  in  1  MTLO: write wd into LO
- wd  in  32  data for MTHI/MTLO
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States:
  - IDLE: `start` goes to RUN. Operands are latched and the counter is set to 0.
  - RUN: one iteration per clock for 32 cycles. When count reaches 31, go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
- Signed ops (op[0]=1) work on absolute values of a and b, latched at start. The sign is fixed up in FIX.
- Multiply:
  - Shift-add, one multiplier bit per cycle, 64-bit product.
  - {hi,lo} = product.
  - Negate the product if sign(a)^sign(b) on MULT.
- Divide:
  - Restoring, one quotient bit per cycle.
  - lo = quotient, hi = remainder.
  - Signed results truncate toward zero: quotient is negated if sign(a)^sign(b); remainder takes the sign of a.
- Divide by zero: no trap. Result is lo=0xFFFFFFFF and hi=a (original, unmodified a), for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - Apply at the clock edge when in IDLE and start=0.
  - we_hi and we_lo may both be high in the same cycle.
- Priority in IDLE: start wins over we_hi/we_lo. A simultaneous write is discarded.
- During RUN/FIX, start, we_hi and we_lo are ignored. hi/lo hold their previous values until FIX.
- Operand changes after the start edge have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset also applies mid-operation; the partial result is discarded.
- Start is accepted on edge E0. busy=1 from E0 until E33. Iterations run on edges E1..E32; HI/LO are written on E33.
- done=1 for exactly the cycle between E33 and E34. busy=0 in that same cycle.
- Latency is 33 clocks from the start edge to HI/LO valid, identical for every op including divide by zero.
- A new start is accepted on E33 itself if start is high while the state is FIX? No: it is accepted earliest on E34, the first edge in IDLE.
- hi/lo outputs come straight from registers. There is no combinational path from the inputs.
- MTHI/MTLO results are visible the cycle after the write edge. done is not asserted for them.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - busy high for 33 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001, with done pulsed once.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Interference check:
  - Start MULTU 3*4.
  - At cycle 10, pulse start with op=DIVU and pulse we_hi with wd=0xDEAD; both are ignored.
  - Result is hi=0, lo=12.
  - Then MTLO wd=0x1234 in IDLE gives lo=0x1234 next cycle, with no done pulse.
  - Finally, assert reset at cycle 15 of a new op: busy=0, done=0, hi=0, lo=0 after that edge.
